bram1_port_arbiter: RTL

- Shares one single-ported, optionally pipelined, file-loaded BRAM between two requesters, A and B.
- Arbitrates per cycle, drives the BRAM port, and returns read data to the requester that issued the read.
- Tracks read latency in a tag pipeline: 1 cycle when non-pipelined, 2 cycles when pipelined.
- Provides a clear sequencer that sweeps a fill value over the whole memory; requesters are stalled during the sweep.

---
 rtl/bram1_port_arbiter_pkg.sv | 25 ++
 rtl/bram1_rd_tag_pipe.sv | 34 +++
 rtl/bram1_port_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bram1_port_arbiter_pkg.sv
`default_nettype none
//============================================================================
// bram1_port_arbiter_pkg - FSM state and read-tag types for the BRAM arbiter
// Rev 1.0
//============================================================================
package bram1_port_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

  typedef enum logic [0:0] {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  typedef struct packed {
    logic   read;
    owner_t owner;
  } rd_tag_t;

endpackage

`default_nettype wire

// File: rtl/bram1_rd_tag_pipe.sv
`default_nettype none
//============================================================================
// bram1_rd_tag_pipe - shift register aligning read tags with BRAM_DO
// Rev 1.0
//============================================================================
module bram1_rd_tag_pipe
  import bram1_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    CLK,
  input  logic    RST,
  input  rd_tag_t i_push_tag,
  output logic    o_tag_valid,
  output owner_t  o_tag_owner
);

  rd_tag_t r_pipe [DEPTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_push_tag;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag_valid = r_pipe[DEPTH-1].read;
  assign o_tag_owner = r_pipe[DEPTH-1].owner;

endmodule

`default_nettype wire

// File: rtl/bram1_port_arbiter.sv
`default_nettype none
//============================================================================
// bram1_port_arbiter - two-requester arbiter and clear sequencer for one BRAM
// Optional: BRAM_ARB_RR_EN selects round-robin (else fixed A-over-B priority)
// Rev 1.0
//============================================================================
module bram1_port_arbiter
  import bram1_port_arbiter_pkg::*;
#(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int MEMSIZE    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  A_REQ_VALID,
  output logic                  A_REQ_READY,
  input  logic                  A_REQ_WE,
  input  logic [ADDR_WIDTH-1:0] A_REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] A_REQ_DATA,
  output logic                  A_RSP_VALID,
  output logic [DATA_WIDTH-1:0] A_RSP_DATA,
  input  logic                  B_REQ_VALID,
  output logic                  B_REQ_READY,
  input  logic                  B_REQ_WE,
  input  logic [ADDR_WIDTH-1:0] B_REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] B_REQ_DATA,
  output logic                  B_RSP_VALID,
  output logic [DATA_WIDTH-1:0] B_RSP_DATA,
  input  logic                  CLR_START,
  input  logic [DATA_WIDTH-1:0] CLR_VALUE,
  output logic                  CLR_BUSY,
  output logic                  BRAM_EN,
  output logic                  BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);

  localparam logic [ADDR_WIDTH:0] c_LAST = (ADDR_WIDTH+1)'(MEMSIZE - 1);

  arb_state_t            r_state;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [DATA_WIDTH-1:0] r_clr_val;

  logic    w_idle, w_a_wins, w_grant_a, w_grant_b;
  rd_tag_t w_push_tag;
  logic    w_tag_valid;
  owner_t  w_tag_owner;

  // RST gates the grant so nothing reaches the BRAM while reset is held.
  assign w_idle = (r_state == ST_IDLE) && !RST && !CLR_START;

`ifdef BRAM_ARB_RR_EN
  owner_t r_rr_ptr;

  assign w_a_wins = !B_REQ_VALID || (r_rr_ptr == OWN_A);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            r_rr_ptr <= OWN_A;
    else if (w_grant_a) r_rr_ptr <= OWN_B;
    else if (w_grant_b) r_rr_ptr <= OWN_A;
  end
`else
  assign w_a_wins = 1'b1;
`endif

  assign w_grant_a   = w_idle && A_REQ_VALID && w_a_wins;
  assign w_grant_b   = w_idle && B_REQ_VALID && !w_grant_a;
  assign A_REQ_READY = w_grant_a;
  assign B_REQ_READY = w_grant_b;
  assign CLR_BUSY    = (r_state == ST_CLEAR);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_clr_val <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (CLR_START) begin
            r_state   <= ST_CLEAR;
            r_cnt     <= '0;
            r_clr_val <= CLR_VALUE;
          end
        end
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    BRAM_EN   = 1'b0;
    BRAM_WE   = 1'b0;
    BRAM_ADDR = '0;
    BRAM_DI   = '0;
    if (r_state == ST_CLEAR) begin
      BRAM_EN   = 1'b1;
      BRAM_WE   = 1'b1;
      BRAM_ADDR = r_cnt[ADDR_WIDTH-1:0];
      BRAM_DI   = r_clr_val;
    end else if (w_grant_a) begin
      BRAM_EN   = 1'b1;
      BRAM_WE   = A_REQ_WE;
      BRAM_ADDR = A_REQ_ADDR;
      BRAM_DI   = A_REQ_DATA;
    end else if (w_grant_b) begin
      BRAM_EN   = 1'b1;
      BRAM_WE   = B_REQ_WE;
      BRAM_ADDR = B_REQ_ADDR;
      BRAM_DI   = B_REQ_DATA;
    end
  end

  assign w_push_tag.read  = (w_grant_a && !A_REQ_WE) || (w_grant_b && !B_REQ_WE);
  assign w_push_tag.owner = w_grant_b ? OWN_B : OWN_A;

  bram1_rd_tag_pipe #(
    .DEPTH (1 + PIPELINED)
  ) u_tag_pipe (
    .CLK         (CLK),
    .RST         (RST),
    .i_push_tag  (w_push_tag),
    .o_tag_valid (w_tag_valid),
    .o_tag_owner (w_tag_owner)
  );

  assign A_RSP_VALID = w_tag_valid && (w_tag_owner == OWN_A);
  assign B_RSP_VALID = w_tag_valid && (w_tag_owner == OWN_B);
  assign A_RSP_DATA  = BRAM_DO;
  assign B_RSP_DATA  = BRAM_DO;

endmodule

`default_nettype wire
